mem_port_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch requester and the load/store requester of the MIPS core. It sequences one memory transaction at a time over a req/ack handshake and returns read data to the winning requester. It raises a stall that freezes the PC while any access is outstanding. Includes a starvation guard for fetch and a timeout watchdog that flags a sticky bus error.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the MIPS core's fetch and load/store requesters onto one memory port,
// one req/ack transaction at a time, with a fetch starvation guard and a timeout watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall,
  output logic              bus_error
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA_WAIT  = 2'd2;

  localparam int                   STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0]  STREAK_ONE = STREAK_W'(1);
  localparam logic [7:0]           TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0]           SIZE_WORD  = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [7:0]          tmo_q,       tmo_d;
  logic                m_req_q,     m_req_d;
  logic                m_we_q,      m_we_d;
  logic [1:0]          m_size_q,    m_size_d;
  logic [ADDR_W-1:0]   m_addr_q,    m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,   m_wdata_d;
  logic                f_ready_q,   f_ready_d;
  logic                d_ready_q,   d_ready_d;
  logic [DATA_W-1:0]   f_rdata_q,   f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                bus_error_q, bus_error_d;

  // A requester whose ready is high this cycle is still holding its finished request.
  logic f_pend_s;
  logic d_pend_s;
  assign f_pend_s = f_req & ~f_ready_q;
  assign d_pend_s = d_req & ~d_ready_q;

  // Arbitration, transaction sequencing, streak and timeout next-state logic
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    f_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_error_d = bus_error_q;

    case (state_q)
      ST_IDLE: begin
        if (d_pend_s && !(f_pend_s && (streak_q == STREAK_MAX))) begin
          state_d   = ST_DATA_WAIT;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          tmo_d     = 8'd0;
          if (f_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : (streak_q + STREAK_ONE);
          end else begin
            streak_d = '0;
          end
        end else if (f_pend_s) begin
          state_d   = ST_FETCH_WAIT;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_size_d  = SIZE_WORD;
          m_addr_d  = f_addr;
          m_wdata_d = '0;
          tmo_d     = 8'd0;
          streak_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH_WAIT, ST_DATA_WAIT: begin
        // An ack on the timeout edge completes normally.
        if (m_ack || (tmo_q == TMO_LAST)) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          if (!m_ack) begin
            bus_error_d = 1'b1;
          end else begin
            bus_error_d = bus_error_q;
          end
          if (state_q == ST_FETCH_WAIT) begin
            f_ready_d = 1'b1;
            f_rdata_d = m_ack ? m_rdata : '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = m_ack ? m_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      tmo_q       <= 8'd0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_size_q    <= 2'd0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      f_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      f_ready_q   <= f_ready_d;
      d_ready_q   <= d_ready_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_size    = m_size_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign f_ready   = f_ready_q;
  assign d_ready   = d_ready_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_error = bus_error_q;
  assign stall     = f_pend_s | d_pend_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester agents, a memory responder and
// a transaction-level arbitration model feed a scoreboard checked by monitors.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 255;

  typedef struct { int d; logic [31:0] v; } scr_t;
  typedef struct { logic [31:0] v; bit err; int c; } rd_t;
  typedef struct { bit is_data; bit is_store; } who_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [1:0]  d_size = 2'd0;
  logic        f_ready, d_ready, m_req, m_we, stall, bus_error;
  logic [1:0]  m_size;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0, n_fail = 0;
  int   f_pct = 0, d_pct = 0;
  int   n_done_f = 0, n_done_d = 0;
  bit   first_f = 1'b1, first_d = 1'b1;
  bit   err_m = 1'b0;
  scr_t scr_q[$];
  rd_t  rd_q[$];
  who_t who_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int total_done();
    return n_done_f + n_done_d;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);     chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_size"}, m_size, 0);   chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0); chk({tag, "_f_ready"}, f_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0); chk({tag, "_f_rdata"}, f_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0); chk({tag, "_bus_error"}, bus_error, 0);
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    for (int i = 0; i < bound && total_done() < target; i++) @(negedge clk);
    chk(name, total_done() >= target, 1);
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int i = 0; i < bound && (f_req || d_req || m_req); i++) @(negedge clk);
    chk(name, f_req | d_req | m_req, 0);
  endtask

  // Fetch requester: holds f_req until f_ready; pc wanders while waiting
  initial begin : fetch_agent
    bit fixed;
    fixed = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!f_req || f_ready) begin
        f_req = int'($urandom_range(99)) < f_pct;
        fixed = 1'b0;
        if (f_req && first_f) begin
          first_f = 1'b0; fixed = 1'b1; f_addr = 32'h0040_0000;
        end
      end
      if (!fixed) f_addr = $urandom;
    end
  end

  // Load/store requester: holds d_req until d_ready; fields wander while waiting
  initial begin : data_agent
    bit fixed;
    fixed = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!d_req || d_ready) begin
        d_req = int'($urandom_range(99)) < d_pct;
        fixed = 1'b0;
        if (d_req && first_d) begin
          first_d = 1'b0; fixed = 1'b1;
          d_we = 1'b1; d_size = 2'd2; d_addr = 32'h1001_0000; d_wdata = 32'h1234_5678;
        end
      end
      if (!fixed) begin
        d_we = 1'($urandom_range(1)); d_size = 2'($urandom_range(2));
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
  end

  // Memory: acks in the dly-th m_req cycle (dly 0 = never) and predicts the completion
  initial begin : mem_model
    int cnt, dly;
    logic [31:0] val;
    scr_t s;
    rd_t e;
    cnt = 0; dly = 1; val = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = 0; m_ack = 1'b0;
      end else if (m_req) begin
        if (cnt == 0) begin
          if (scr_q.size() > 0) begin
            s = scr_q.pop_front(); dly = s.d; val = s.v;
          end else begin
            dly = int'($urandom_range(6, 1)); val = $urandom;
          end
        end
        cnt++;
        if (dly != 0 && cnt == dly) begin
          m_ack = 1'b1; m_rdata = val;
          e.v = val; e.err = 1'b0; e.c = cyc; rd_q.push_back(e);
        end else begin
          m_ack = 1'b0; m_rdata = $urandom;
          if (dly == 0 && cnt == TMO) begin
            e.v = '0; e.err = 1'b1; e.c = cyc; rd_q.push_back(e);
          end
        end
      end else begin
        cnt = 0; m_ack = ($urandom_range(7) == 0); m_rdata = $urandom;
      end
    end
  end

  // Arbitration model: predicts each grant from requests seen in the preceding idle cycle
  initial begin : grant_mon
    bit   prev_mreq, rec_pf, rec_pd, rec_fr, rec_dwe, exp_d;
    logic [1:0]  rec_dsize, g_size;
    logic [31:0] rec_faddr, rec_daddr, rec_dwdata, g_addr, g_wdata;
    bit   g_we;
    int   streak_m;
    who_t w;
    prev_mreq = 1'b0; rec_pf = 1'b0; rec_pd = 1'b0; rec_fr = 1'b0; rec_dwe = 1'b0;
    rec_dsize = 2'd0; rec_faddr = '0; rec_daddr = '0; rec_dwdata = '0;
    g_size = 2'd0; g_addr = '0; g_wdata = '0; g_we = 1'b0; streak_m = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_mreq = 1'b0; streak_m = 0;
      end else begin
        chk("stall", stall, (f_req & ~f_ready) | (d_req & ~d_ready));
        if (m_req && !prev_mreq) begin
          if (!rec_pf && !rec_pd) begin
            chk("spurious_grant", m_req, 0);
          end else begin
            exp_d = rec_pd && !(rec_pf && streak_m == MAXS);
            g_addr  = exp_d ? rec_daddr : rec_faddr;
            g_we    = exp_d ? rec_dwe : 1'b0;
            g_size  = exp_d ? rec_dsize : 2'd2;
            g_wdata = m_wdata;
            chk("grant_addr", m_addr, g_addr);
            chk("grant_we", m_we, g_we);
            chk("grant_size", m_size, g_size);
            if (exp_d) begin
              g_wdata = rec_dwdata;
              chk("grant_wdata", m_wdata, g_wdata);
              streak_m = rec_fr ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
            end else begin
              streak_m = 0;
            end
            w.is_data = exp_d; w.is_store = exp_d && rec_dwe;
            who_q.push_back(w);
          end
        end else if (m_req) begin
          chk("hold_addr", m_addr, g_addr);
          chk("hold_we", m_we, g_we);
          chk("hold_size", m_size, g_size);
          chk("hold_wdata", m_wdata, g_wdata);
        end else if (!prev_mreq && (rec_pf || rec_pd)) begin
          chk("missed_grant", m_req, 1);
        end
        prev_mreq = m_req;
      end
      rec_pf = f_req & ~f_ready; rec_pd = d_req & ~d_ready; rec_fr = f_req;
      rec_faddr = f_addr; rec_daddr = d_addr; rec_dwe = d_we;
      rec_dsize = d_size; rec_dwdata = d_wdata;
    end
  end

  // Completion monitor: pops the scoreboard on every ready pulse
  initial begin : ready_mon
    bit   pfr, pdr;
    who_t w;
    rd_t  e;
    pfr = 1'b0; pdr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pfr = 1'b0; pdr = 1'b0; err_m = 1'b0;
        who_q.delete(); rd_q.delete();
      end else begin
        if (f_ready || d_ready) begin
          chk("ready_onehot", f_ready & d_ready, 0);
          chk("ready_pulse", (f_ready & pfr) | (d_ready & pdr), 0);
          if (who_q.size() == 0 || rd_q.size() == 0) begin
            chk("unexpected_ready", f_ready | d_ready, 0);
          end else begin
            w = who_q.pop_front(); e = rd_q.pop_front();
            chk("ready_port", d_ready, w.is_data);
            chk("ready_latency", cyc, e.c + 1);
            if (!w.is_store || e.err) chk("rdata", d_ready ? d_rdata : f_rdata, e.v);
            if (e.err) err_m = 1'b1;
            if (d_ready) n_done_d++;
            else n_done_f++;
          end
        end
        chk("bus_error", bus_error, err_m);
        pfr = f_ready; pdr = d_ready;
      end
    end
  end

  initial begin : main
    int base;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // Fetch alone against a zero-wait memory
    scr_q.push_back('{1, 32'h8C22_0004});
    f_pct = 100;
    wait_done(1, 50, "fetch_only_done");
    f_pct = 0;
    wait_idle(100, "idle_after_fetch");

    // Both requesters continuously busy: store wins first, then streak guard
    f_pct = 100; d_pct = 100;
    base = total_done();
    wait_done(base + 16, 400, "busy_done");

    // Random traffic with slow ack, boundary ack on the last cycle, and a timeout
    f_pct = 50; d_pct = 50;
    scr_q.push_back('{5, $urandom});
    scr_q.push_back('{255, $urandom});
    scr_q.push_back('{0, 32'h0});
    scr_q.push_back('{1, $urandom});
    for (int i = 0; i < 2000 && scr_q.size() > 0; i++) @(negedge clk);
    chk("script_consumed", scr_q.size(), 0);
    base = total_done();
    wait_done(base + 30, 1500, "random_done");

    // Reset while a data access is outstanding
    f_pct = 0; d_pct = 0;
    wait_idle(600, "idle_before_reset");
    scr_q.push_back('{0, 32'h0});
    d_pct = 100;
    for (int i = 0; i < 20 && !m_req; i++) @(negedge clk);
    chk("reset_test_grant", m_req, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    scr_q.delete();
    #2 rst_n = 1'b1;
    base = total_done();
    wait_done(base + 1, 60, "post_reset_done");

    f_pct = 50;
    base = total_done();
    wait_done(base + 8, 300, "final_done");
    f_pct = 0; d_pct = 0;
    wait_idle(400, "final_idle");
    repeat (3) @(negedge clk);
    chk("who_q_empty", who_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
